// File: rtl/fpu_div.sv
// ---------------------------------------------------------------------------
// fpu_div
// Sequential IEEE-754 single-precision divider (o_32_div = i_32_a / i_32_b).
// A radix-2 restoring division yields one quotient bit per cycle, then one
// cycle normalises and rounds to nearest even. A single operation is in
// flight at a time, and special operands run through the same pipeline so
// the latency never changes.
//
// Ports
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_valid   : operands valid
//   o_ready   : operands taken on an edge where i_valid & o_ready
//   i_32_a    : dividend
//   i_32_b    : divisor
//   o_valid   : one-cycle pulse, result valid
//   o_32_div  : quotient, held until the next o_valid
//   o_dz      : divide-by-zero flag, held with o_32_div
// ---------------------------------------------------------------------------
module fpu_div #(
   parameter int SIZE_DATA = 32,
   parameter int NUM_ITER  = 26
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [SIZE_DATA-1:0] i_32_a,
   input  logic [SIZE_DATA-1:0] i_32_b,
   output logic                 o_valid,
   output logic [SIZE_DATA-1:0] o_32_div,
   output logic                 o_dz
);

   localparam int CNT_W = $clog2(NUM_ITER);

   typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;
   typedef enum logic [1:0] {SPC_NONE, SPC_NAN, SPC_INF, SPC_ZERO} spc_t;

   state_t state_q, state_d;

   logic accept, divStep, rndStep, publish;

   // operand fields and special-case classification
   logic [7:0]  expA, expB;
   logic [22:0] fracA, fracB;
   logic        aZero, bZero, aInf, bInf, aNan, bNan;
   logic        signIn, dzIn;
   spc_t        spcIn;
   logic signed [9:0] expDiff;

   // working registers
   logic               sign_q;
   logic signed [9:0]  exp_q;
   logic [23:0]        divisor_q;
   logic [25:0]        rem_q;
   logic [25:0]        quot_q;
   logic [CNT_W-1:0]   cnt_q;
   spc_t               spc_q;
   logic               dz_q;
   logic [SIZE_DATA-1:0] res_q;

   // output registers
   logic                 oValid_q;
   logic [SIZE_DATA-1:0] oDiv_q;
   logic                 oDz_q;

   // division step
   logic [25:0] remTrial, remNext, rem_d;
   logic        quotBit;

   // rounding
   logic [23:0]       mant;
   logic              guard, sticky, roundUp, mantCarry;
   logic [22:0]       fracRnd;
   logic signed [9:0] expNorm, expFin;
   logic [SIZE_DATA-1:0] res_d;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: DIV stays for NUM_ITER cycles, DONE may re-accept
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = DIV;
         DIV:  if (cnt_q == CNT_W'(NUM_ITER - 1)) state_d = RND;
         RND:  state_d = DONE;
         DONE: state_d = accept ? DIV : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State decode: handshake and datapath strobes
   always_comb begin
      o_ready = 1'b0;
      divStep = 1'b0;
      rndStep = 1'b0;
      publish = 1'b0;
      case (state_q)
         IDLE: o_ready = 1'b1;
         DIV:  divStep = 1'b1;
         RND:  rndStep = 1'b1;
         DONE: begin
            o_ready = 1'b1;
            publish = 1'b1;
         end
         default: ;
      endcase
   end

   assign accept = i_valid & o_ready;

   assign expA  = i_32_a[30:23];
   assign expB  = i_32_b[30:23];
   assign fracA = i_32_a[22:0];
   assign fracB = i_32_b[22:0];
   assign signIn  = i_32_a[31] ^ i_32_b[31];
   assign expDiff = $signed({2'b00, expA}) - $signed({2'b00, expB}) + 10'sd127;

   // Special classes in priority order; exp==0 counts as zero (denormals flushed)
   always_comb begin
      aZero = (expA == 8'h00);
      bZero = (expB == 8'h00);
      aInf  = (expA == 8'hFF) && (fracA == 23'd0);
      bInf  = (expB == 8'hFF) && (fracB == 23'd0);
      aNan  = (expA == 8'hFF) && (fracA != 23'd0);
      bNan  = (expB == 8'hFF) && (fracB != 23'd0);
      spcIn = SPC_NONE;
      dzIn  = 1'b0;
      if (aNan | bNan | (aZero & bZero) | (aInf & bInf)) begin
         spcIn = SPC_NAN;
      end else if (aInf) begin
         spcIn = SPC_INF;
      end else if (bZero) begin
         spcIn = SPC_INF;
         dzIn  = 1'b1;
      end else if (aZero | bInf) begin
         spcIn = SPC_ZERO;
      end
   end

   // Restoring step: remainder is compared against the divisor, then doubled
   always_comb begin
      remTrial = rem_q - {2'b00, divisor_q};
      quotBit  = (rem_q >= {2'b00, divisor_q});
      remNext  = quotBit ? remTrial : rem_q;
      rem_d    = remNext << 1;
   end

   // Normalise, round to nearest even, range-check and apply specials.
   // The hidden bit of mant is always set, so a carry out of the 24-bit
   // mantissa happens exactly when all bits are ones and we round up.
   always_comb begin
      if (quot_q[25]) begin
         mant    = quot_q[25:2];
         guard   = quot_q[1];
         sticky  = (rem_q != 26'd0) | quot_q[0];
         expNorm = exp_q;
      end else begin
         mant    = quot_q[24:1];
         guard   = quot_q[0];
         sticky  = (rem_q != 26'd0);
         expNorm = exp_q - 10'sd1;
      end
      roundUp   = guard & (sticky | mant[0]);
      mantCarry = roundUp & (&mant);
      fracRnd   = mant[22:0] + {22'd0, roundUp};
      expFin    = mantCarry ? (expNorm + 10'sd1) : expNorm;

      if (expFin >= 10'sd255) begin
         res_d = {sign_q, 8'hFF, 23'd0};
      end else if (expFin <= 10'sd0) begin
         res_d = {sign_q, 31'd0};
      end else begin
         res_d = {sign_q, expFin[7:0], fracRnd};
      end

      case (spc_q)
         SPC_NAN:  res_d = 32'h7FC00000;
         SPC_INF:  res_d = {sign_q, 8'hFF, 23'd0};
         SPC_ZERO: res_d = {sign_q, 31'd0};
         default:  ;
      endcase
   end

   // Working registers: latch operands on accept, iterate in DIV, round in RND
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sign_q    <= 1'b0;
         exp_q     <= '0;
         divisor_q <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         cnt_q     <= '0;
         spc_q     <= SPC_NONE;
         dz_q      <= 1'b0;
         res_q     <= '0;
      end else begin
         if (accept) begin
            sign_q    <= signIn;
            exp_q     <= expDiff;
            divisor_q <= {1'b1, fracB};
            rem_q     <= {3'b001, fracA};
            quot_q    <= '0;
            cnt_q     <= '0;
            spc_q     <= spcIn;
            dz_q      <= dzIn;
         end else if (divStep) begin
            rem_q  <= rem_d;
            quot_q <= {quot_q[24:0], quotBit};
            cnt_q  <= cnt_q + CNT_W'(1);
         end
         if (rndStep) begin
            res_q <= res_d;
         end
      end
   end

   // Output registers: publish the rounded result while leaving DONE
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         oValid_q <= 1'b0;
         oDiv_q   <= '0;
         oDz_q    <= 1'b0;
      end else begin
         oValid_q <= publish;
         if (publish) begin
            oDiv_q <= res_q;
            oDz_q  <= dz_q;
         end
      end
   end

   assign o_valid  = oValid_q;
   assign o_32_div = oDiv_q;
   assign o_dz     = oDz_q;

endmodule

// File: tb/tb_fpu_div.sv
// ---------------------------------------------------------------------------
// tb_fpu_div
// Self-checking bench for fpu_div. Expected results are pushed to a
// scoreboard queue at the accept edge and popped whenever o_valid is seen,
// where result, divide-by-zero flag and latency are compared.
// ---------------------------------------------------------------------------
module tb_fpu_div;

   localparam int N_VEC   = 23;
   localparam int LATENCY = 28;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        dz;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        dz;
      int          acceptCyc;
      int          tag;
   } exp_t;

   logic        i_clk   = 1'b0;
   logic        i_rst_n = 1'b1;
   logic        i_valid = 1'b0;
   logic [31:0] i_32_a  = '0;
   logic [31:0] i_32_b  = '0;
   logic        o_ready;
   logic        o_valid;
   logic [31:0] o_32_div;
   logic        o_dz;

   vec_t vecs [N_VEC];
   exp_t sbQueue [$];
   exp_t monExp;
   int   checks   = 0;
   int   errors   = 0;
   int   cycleCnt = 0;
   int   opTag    = 0;
   int   lowCnt;

   fpu_div #(
      .SIZE_DATA (32),
      .NUM_ITER  (26)
   ) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_32_a   (i_32_a),
      .i_32_b   (i_32_b),
      .o_valid  (o_valid),
      .o_32_div (o_32_div),
      .o_dz     (o_dz)
   );

   // Free-running clock and a cycle counter used for latency checks
   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cycleCnt <= cycleCnt + 1;

   // One comparison: counts it and reports a mismatch
   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic pushExpected(input logic [31:0] res, input logic dz, input int acc);
      exp_t e;
      e.res       = res;
      e.dz        = dz;
      e.acceptCyc = acc;
      e.tag       = opTag;
      opTag++;
      sbQueue.push_back(e);
   endtask

   // Wait for o_ready, present one operation for exactly one accept edge
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic dz);
      int waitCnt = 0;
      @(negedge i_clk);
      while (!o_ready && waitCnt < 100) begin
         @(negedge i_clk);
         waitCnt++;
      end
      if (!o_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL acceptWait: o_ready got 0, expected 1");
      end else begin
         i_32_a  = a;
         i_32_b  = b;
         i_valid = 1'b1;
         @(posedge i_clk);
         #1;
         pushExpected(res, dz, cycleCnt);
         i_valid = 1'b0;
         i_32_a  = $urandom();
         i_32_b  = $urandom();
      end
   endtask

   // Bounded wait until every expected result has been seen
   task automatic waitDrain();
      int n = 0;
      while (sbQueue.size() != 0 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      if (sbQueue.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: pending results got %0d, expected 0", sbQueue.size());
         sbQueue.delete();
      end
   endtask

   // Scoreboard consumer: every o_valid pulse must match the oldest entry
   always @(negedge i_clk) begin
      if (o_valid) begin
         if (sbQueue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL spuriousValid: o_valid got 1, expected 0");
         end else begin
            monExp = sbQueue.pop_front();
            checkOutput($sformatf("op%0d result", monExp.tag), o_32_div, monExp.res);
            checkOutput($sformatf("op%0d dz", monExp.tag), {31'd0, o_dz}, {31'd0, monExp.dz});
            checkOutput($sformatf("op%0d latency", monExp.tag), cycleCnt - monExp.acceptCyc, LATENCY);
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
      vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0};
      vecs[2]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0};
      vecs[3]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1};
      vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0};
      vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0};
      vecs[6]  = '{32'h40000000, 32'h7F800000, 32'h00000000, 1'b0};
      vecs[7]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0};
      vecs[8]  = '{32'h00800000, 32'h4B000000, 32'h00000000, 1'b0};
      vecs[9]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0};
      vecs[10] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 1'b0};
      vecs[11] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 1'b0};
      vecs[12] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0};
      vecs[13] = '{32'h3F800000, 32'hFFC00000, 32'h7FC00000, 1'b0};
      vecs[14] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0};
      vecs[15] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0};
      vecs[16] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0};
      vecs[17] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0};
      vecs[18] = '{32'h3F800000, 32'h00000001, 32'h7F800000, 1'b1};
      vecs[19] = '{32'h3F800000, 32'h3F000000, 32'h40000000, 1'b0};
      vecs[20] = '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0};
      vecs[21] = '{32'h00800000, 32'h3F800001, 32'h00000000, 1'b0};
      vecs[22] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0};

      // Reset values
      #2 i_rst_n = 1'b0;
      #1;
      checkOutput("resetReady", {31'd0, o_ready}, 32'd1);
      checkOutput("resetValid", {31'd0, o_valid}, 32'd0);
      checkOutput("resetDiv", o_32_div, 32'd0);
      checkOutput("resetDz", {31'd0, o_dz}, 32'd0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;

      // First operation: o_ready must stay low for 27 cycles
      applyStimulus(vecs[0].a, vecs[0].b, vecs[0].res, vecs[0].dz);
      lowCnt = 0;
      for (int k = 0; k < LATENCY - 1; k++) begin
         @(negedge i_clk);
         if (!o_ready) lowCnt++;
      end
      checkOutput("busyReadyLow", lowCnt, LATENCY - 1);
      @(negedge i_clk);
      checkOutput("readyAtDone", {31'd0, o_ready}, 32'd1);

      // Remaining table vectors, issued as fast as the block accepts them
      for (int i = 1; i < N_VEC; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz);
      end
      waitDrain();

      // Handshake: op2 held on the inputs throughout op1, accepted at E28
      @(negedge i_clk);
      i_32_a  = 32'h40000000;
      i_32_b  = 32'h40400000;
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      pushExpected(32'h3F2AAAAB, 1'b0, cycleCnt);
      pushExpected(32'hC0400000, 1'b0, cycleCnt + LATENCY);
      i_32_a = 32'hC0C00000;
      i_32_b = 32'h40000000;
      repeat (LATENCY - 1) @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("hsReadyAtDone", {31'd0, o_ready}, 32'd1);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_32_a  = $urandom();
      i_32_b  = $urandom();
      waitDrain();

      // Reset mid-operation: leave a nonzero result and o_dz=1 on the outputs first
      applyStimulus(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1);
      waitDrain();
      applyStimulus(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0);
      repeat (10) @(posedge i_clk);
      #3 i_rst_n = 1'b0;
      #1;
      checkOutput("midResetReady", {31'd0, o_ready}, 32'd1);
      checkOutput("midResetValid", {31'd0, o_valid}, 32'd0);
      checkOutput("midResetDiv", o_32_div, 32'd0);
      checkOutput("midResetDz", {31'd0, o_dz}, 32'd0);
      sbQueue.delete();
      repeat (3) @(negedge i_clk);

      // New op accepted on the first edge after release
      i_32_a  = 32'h40C00000;
      i_32_b  = 32'h40000000;
      i_valid = 1'b1;
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      pushExpected(32'h40400000, 1'b0, cycleCnt);
      i_valid = 1'b0;
      i_32_a  = $urandom();
      i_32_b  = $urandom();
      waitDrain();
      repeat (5) @(negedge i_clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
